// File: rtl/chng_seq_ctrl.sv
// Change-list sequencer: fetches each change record, runs the Y-value filter,
// then ITERS calc_y iterations, and arbitrates the shared yMem read port.
module chng_seq_ctrl #(
  parameter int ITERS    = 4,
  parameter int YMEM_LAT = 1,
  parameter int WDOG_MAX = 1023
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] num_chng,
  output logic [15:0] chng_addr,
  output logic        chng_rd,
  input  logic [79:0] chng_rdata,
  output logic [15:0] chng_row,
  output logic [15:0] chng_col,
  output logic [23:0] chng_real,
  output logic [23:0] chng_img,
  output logic        filt_EN,
  input  logic        filt_done,
  output logic        calc_start,
  input  logic        calc_done,
  input  logic        filt_rd_req,
  input  logic        calc_rd_req,
  input  logic [15:0] filt_y_row,
  input  logic [15:0] calc_y_row,
  output logic        ymem_rd,
  output logic [15:0] ymem_addr,
  output logic        filt_dataReady,
  output logic        calc_dataReady,
  output logic        busy,
  output logic [7:0]  iter_cnt,
  output logic        op_Done,
  output logic        op_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_FILT, S_CALC, S_NEXT, S_DONE
  } state_t;

  localparam logic [7:0]  ITERS_L  = 8'(ITERS);
  localparam logic [15:0] WDOG_LIM = 16'(WDOG_MAX - 1);

  state_t              state, state_nxt;
  logic [15:0]         idx, idx_inc, num_q, wdog;
  logic [7:0]          iter_inc;
  logic                calc_last, abort, filt_iss, calc_iss, wdog_clr;
  logic [YMEM_LAT-1:0] filt_vld_p, calc_vld_p;

  assign idx_inc   = idx + 16'd1;
  assign iter_inc  = iter_cnt + 8'd1;
  assign calc_last = (iter_inc == ITERS_L);

  assign busy           = (state != S_IDLE);
  assign op_Done        = (state == S_DONE);
  assign filt_dataReady = filt_vld_p[YMEM_LAT-1];
  assign calc_dataReady = calc_vld_p[YMEM_LAT-1];

  // Watchdog restarts whenever the sequence makes progress.
  assign wdog_clr = ((state_nxt == S_FILT) && (state != S_FILT)) ||
                    ((state_nxt == S_CALC) && (state != S_CALC)) ||
                    ((state == S_CALC) && calc_done);

  always_comb begin
    state_nxt = state;
    abort     = 1'b0;
    chng_rd   = 1'b0;
    chng_addr = 16'd0;
    filt_EN   = 1'b0;
    ymem_rd   = 1'b0;
    ymem_addr = 16'd0;
    filt_iss  = 1'b0;
    calc_iss  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = (num_chng == 16'd0) ? S_DONE : S_FETCH;
      end
      S_FETCH: begin
        chng_rd   = 1'b1;
        chng_addr = idx;
        state_nxt = S_LOAD;
      end
      S_LOAD: state_nxt = S_FILT;
      S_FILT: begin
        filt_EN   = 1'b1;
        ymem_rd   = filt_rd_req;
        ymem_addr = filt_y_row;
        filt_iss  = filt_rd_req;
        if (filt_done) begin
          state_nxt = S_CALC;
        end else if (wdog == WDOG_LIM) begin
          abort     = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_CALC: begin
        ymem_rd   = calc_rd_req;
        ymem_addr = calc_y_row;
        calc_iss  = calc_rd_req;
        if (calc_done) begin
          if (calc_last) state_nxt = S_NEXT;
        end else if (wdog == WDOG_LIM) begin
          abort     = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_NEXT: state_nxt = (idx_inc == num_q) ? S_DONE : S_FETCH;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      idx        <= 16'd0;
      num_q      <= 16'd0;
      wdog       <= 16'd0;
      iter_cnt   <= 8'd0;
      calc_start <= 1'b0;
      op_err     <= 1'b0;
      chng_row   <= 16'd0;
      chng_col   <= 16'd0;
      chng_real  <= 24'd0;
      chng_img   <= 24'd0;
      filt_vld_p <= '0;
      calc_vld_p <= '0;
    end else begin
      state      <= state_nxt;
      calc_start <= ((state == S_FILT) && filt_done) ||
                    ((state == S_CALC) && calc_done && !calc_last);
      if (abort) op_err <= 1'b1;
      if (wdog_clr) wdog <= 16'd0;
      else if ((state == S_FILT) || (state == S_CALC)) wdog <= wdog + 16'd1;
      case (state)
        S_IDLE: if (start) begin
          num_q  <= num_chng;
          idx    <= 16'd0;
          op_err <= 1'b0;
        end
        S_LOAD: begin
          chng_row  <= chng_rdata[79:64];
          chng_col  <= chng_rdata[63:48];
          chng_real <= chng_rdata[47:24];
          chng_img  <= chng_rdata[23:0];
        end
        S_FILT: if (filt_done) iter_cnt <= 8'd0;
        S_CALC: if (calc_done) iter_cnt <= iter_inc;
        S_NEXT: idx <= idx_inc;
        default: ;
      endcase
      // Read-tag pipeline: tag follows the owner at issue time.
      filt_vld_p[0] <= filt_iss;
      calc_vld_p[0] <= calc_iss;
      for (int i = 1; i < YMEM_LAT; i++) begin
        filt_vld_p[i] <= filt_vld_p[i-1];
        calc_vld_p[i] <= calc_vld_p[i-1];
      end
    end
  end

endmodule

// File: tb/tb_chng_seq_ctrl.sv
// Scoreboard bench for chng_seq_ctrl: planned operation timelines feed expected
// event queues; a negedge monitor pops and compares whatever the DUT presents.
module tb_chng_seq_ctrl;
  localparam int ITERS = 2;
  localparam int LAT   = 2;
  localparam int WDOG  = 15;

  localparam int Q_CHG = 0, Q_FLD = 1, Q_CS = 2, Q_DONE = 3, Q_RD = 4, Q_FRDY = 5, Q_CRDY = 6;

  typedef struct {
    int          cyc;
    logic [79:0] v;
  } ev_t;

  logic        clock, reset, start;
  logic [15:0] num_chng, chng_addr;
  logic        chng_rd;
  logic [79:0] chng_rdata;
  logic [15:0] chng_row, chng_col;
  logic [23:0] chng_real, chng_img;
  logic        filt_EN, filt_done, calc_start, calc_done;
  logic        filt_rd_req, calc_rd_req;
  logic [15:0] filt_y_row, calc_y_row;
  logic        ymem_rd;
  logic [15:0] ymem_addr;
  logic        filt_dataReady, calc_dataReady, busy;
  logic [7:0]  iter_cnt;
  logic        op_Done, op_err;

  chng_seq_ctrl #(.ITERS(ITERS), .YMEM_LAT(LAT), .WDOG_MAX(WDOG)) dut (
    .clock(clock), .reset(reset), .start(start), .num_chng(num_chng),
    .chng_addr(chng_addr), .chng_rd(chng_rd), .chng_rdata(chng_rdata),
    .chng_row(chng_row), .chng_col(chng_col), .chng_real(chng_real), .chng_img(chng_img),
    .filt_EN(filt_EN), .filt_done(filt_done), .calc_start(calc_start), .calc_done(calc_done),
    .filt_rd_req(filt_rd_req), .calc_rd_req(calc_rd_req),
    .filt_y_row(filt_y_row), .calc_y_row(calc_y_row),
    .ymem_rd(ymem_rd), .ymem_addr(ymem_addr),
    .filt_dataReady(filt_dataReady), .calc_dataReady(calc_dataReady),
    .busy(busy), .iter_cnt(iter_cnt), .op_Done(op_Done), .op_err(op_err)
  );

  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  int          rst_cyc = -1000;
  ev_t         evq[7][$];
  logic [79:0] mem[8];
  bit          sch_start[int], sch_fdone[int], sch_cdone[int], sch_rst[int], chk0[int], busy_at[int];
  logic [15:0] sch_num[int];
  int          owner_at[int];
  bit          pend = 1'b0;
  logic [2:0]  pend_a = 3'd0;
  bit          prev_fen = 1'b0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  function automatic void push(input int id, input int cy, input logic [79:0] v);
    ev_t e;
    e.cyc = cy;
    e.v   = v;
    evq[id].push_back(e);
  endfunction

  task automatic chk(input string nm, input logic [159:0] a, input logic [159:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, a, e);
    end
  endtask

  task automatic present(input int id, input string nm, input int c, input logic [79:0] act);
    ev_t e;
    chk({nm, "_expected"}, 160'(evq[id].size() != 0), 160'(1));
    if (evq[id].size() != 0) begin
      e = evq[id].pop_front();
      chk(nm, 160'({32'(c), act}), 160'({32'(e.cyc), e.v}));
    end
  endtask

  // Timeline of one operation derived from the sequencing rules.
  task automatic plan_op(input int s, input int n, input int abort_rec, input bit do_rst,
                         output int done);
    int c, fd, cd, cc, last;
    bit err, stop;
    err = 1'b0; stop = 1'b0; last = 0;
    sch_start[s] = 1'b1;
    sch_num[s]   = 16'(n);
    c = s + 1;
    done = s + 1;
    for (int i = 0; i < n && !stop; i++) begin
      push(Q_CHG, c, 80'(i));
      push(Q_FLD, c + 2, mem[i % 8]);
      if (i == abort_rec) begin
        for (int k = 0; k < WDOG; k++) begin
          owner_at[c + 2 + k] = 1;
          if ($urandom_range(0, 3) == 0) sch_cdone[c + 2 + k] = 1'b1;
        end
        done = c + 2 + WDOG;
        err  = 1'b1;
        stop = 1'b1;
      end else begin
        fd = $urandom_range(1, 8);
        for (int k = 0; k < fd; k++) begin
          owner_at[c + 2 + k] = 1;
          if ($urandom_range(0, 3) == 0) sch_cdone[c + 2 + k] = 1'b1;
        end
        sch_fdone[c + 1 + fd] = 1'b1;
        cc = c + 2 + fd;
        for (int it = 0; it < ITERS && !stop; it++) begin
          push(Q_CS, cc, 80'(it));
          if (do_rst && i == 0 && it == 1) begin
            rst_cyc = cc;
            sch_rst[cc] = 1'b1;
            chk0[cc + 1] = 1'b1;
            owner_at[cc] = 2;
            done = cc;
            stop = 1'b1;
          end else begin
            cd = $urandom_range(0, 4);
            for (int k = 0; k <= cd; k++) begin
              owner_at[cc + k] = 2;
              if ($urandom_range(0, 3) == 0) sch_fdone[cc + k] = 1'b1;
            end
            sch_cdone[cc + cd] = 1'b1;
            last = cc + cd;
            cc   = last + 1;
          end
        end
        if (!stop) begin
          c    = last + 2;
          done = c;
        end
      end
    end
    if (!do_rst) push(Q_DONE, done, 80'(err));
    for (int k = s + 1; k <= done; k++) busy_at[k] = 1'b1;
  endtask

  task automatic drive_cycle(input int c);
    int own;
    own         = owner_at.exists(c) ? owner_at[c] : 0;
    reset       = (c < 3) || sch_rst.exists(c);
    start       = sch_start.exists(c);
    num_chng    = sch_num.exists(c) ? sch_num[c] : 16'($urandom);
    filt_done   = sch_fdone.exists(c);
    calc_done   = sch_cdone.exists(c);
    chng_rdata  = pend ? mem[pend_a] : {16'($urandom), 32'($urandom), 32'($urandom)};
    pend        = chng_rd;
    pend_a      = chng_addr[2:0];
    filt_rd_req = 1'($urandom_range(0, 1));
    calc_rd_req = 1'($urandom_range(0, 1));
    filt_y_row  = 16'($urandom);
    calc_y_row  = 16'($urandom);
    if (own == 1 && filt_done) filt_rd_req = 1'b1;
    if (own == 1 && filt_rd_req) begin
      push(Q_RD, c, 80'(filt_y_row));
      if (!(c <= rst_cyc && c + LAT > rst_cyc)) push(Q_FRDY, c + LAT, 80'(0));
    end
    if (own == 2 && calc_rd_req) begin
      push(Q_RD, c, 80'(calc_y_row));
      if (!(c <= rst_cyc && c + LAT > rst_cyc)) push(Q_CRDY, c + LAT, 80'(0));
    end
  endtask

  task automatic mon_cycle(input int c);
    int own;
    own = owner_at.exists(c) ? owner_at[c] : 0;
    if (chk0.exists(c))
      chk("reset_zero", 160'({chng_addr, chng_rd, chng_row, chng_col, chng_real, chng_img,
                              filt_EN, calc_start, ymem_rd, ymem_addr, filt_dataReady,
                              calc_dataReady, busy, iter_cnt, op_Done, op_err}), 160'(0));
    if (chng_rd) present(Q_CHG, "chng_rd_addr", c, 80'(chng_addr));
    chk("filt_EN", 160'(filt_EN), 160'(own == 1));
    if (filt_EN && !prev_fen)
      present(Q_FLD, "record_fields", c, {chng_row, chng_col, chng_real, chng_img});
    prev_fen = filt_EN;
    if (calc_start) present(Q_CS, "calc_start_iter", c, 80'(iter_cnt));
    if (op_Done) present(Q_DONE, "op_Done_err", c, 80'(op_err));
    chk("busy", 160'(busy), 160'(busy_at.exists(c)));
    if (ymem_rd) present(Q_RD, "ymem_rd_addr", c, 80'(ymem_addr));
    if (own == 0) chk("ymem_idle", 160'({ymem_rd, ymem_addr}), 160'(0));
    if (filt_dataReady) present(Q_FRDY, "filt_dataReady", c, 80'(0));
    if (calc_dataReady) present(Q_CRDY, "calc_dataReady", c, 80'(0));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; num_chng = 16'd0; chng_rdata = 80'd0;
    filt_done = 1'b0; calc_done = 1'b0; filt_rd_req = 1'b0; calc_rd_req = 1'b0;
    filt_y_row = 16'd0; calc_y_row = 16'd0;
    forever begin
      @(posedge clock);
      #1;
      drive_cycle(cyc);
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      if (cyc >= 3) mon_cycle(cyc);
    end
  end

  initial begin
    int s, d;
    for (int i = 0; i < 8; i++) mem[i] = {16'($urandom), 32'($urandom), 32'($urandom)};
    mem[0] = {16'd2, 16'd5, 24'h000100, 24'hFFFF00};
    chk0[3] = 1'b1;
    s = 10;
    plan_op(s, 3, -1, 1'b0, d);
    s = d + 2;
    plan_op(s, 0, -1, 1'b0, d);
    s = d + 1 + $urandom_range(0, 3);
    plan_op(s, 2, 1, 1'b0, d);
    s = d + 2;
    sch_start[s + 5] = 1'b1;
    sch_num[s + 5]   = 16'd7;
    plan_op(s, 4, -1, 1'b0, d);
    s = d + 2;
    plan_op(s, 2, -1, 1'b1, d);
    s = d + 2;
    plan_op(s, 1, -1, 1'b0, d);
    for (int k = 0; k < 4; k++) begin
      s = d + 1 + $urandom_range(0, 3);
      plan_op(s, $urandom_range(1, 5), -1, 1'b0, d);
    end
    while (cyc < d + 12) @(posedge clock);
    @(negedge clock);
    #1;
    for (int id = 0; id < 7; id++) chk($sformatf("leftover_q%0d", id), 160'(evq[id].size()), 160'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
